// File: rtl/decoder_pkg.sv
// Shared mode encodings for the select decoder stream.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_ACC    = 2'b10,
    MODE_CLR    = 2'b11
  } mode_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/decoder_core.sv
// Combinational decode of (select, mode, accumulator) into a result vector and range error.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
) (
  input  logic [SEL_W-1:0] sel,
  input  mode_e            mode,
  input  logic [N_OUT-1:0] acc,
  output logic [N_OUT-1:0] dec,
  output logic             err
);

  logic [31:0]      sel_int;
  logic             out_of_range;
  logic [N_OUT-1:0] onehot;
  logic [N_OUT-1:0] therm;

  assign sel_int      = 32'(sel);
  assign out_of_range = (sel_int >= 32'(N_OUT));

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_bit
      assign onehot[gi] = (sel_int == 32'(gi));
      assign therm[gi]  = (32'(gi) <= sel_int);
    end
  endgenerate

  // Clear ignores the select entirely, so it can never flag a range error.
  always_comb begin
    dec = '0;
    err = 1'b0;
    case (mode)
      MODE_CLR: begin
        dec = '0;
      end
      default: begin
        if (out_of_range) begin
          err = 1'b1;
        end else begin
          case (mode)
            MODE_ONEHOT: dec = onehot;
            MODE_THERM:  dec = therm;
            MODE_ACC:    dec = acc | onehot;
            default:     dec = '0;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/decoder_stream.sv
// Valid/ready select decoder with an output register, one skid entry and an
// accumulate mode whose state advances at accept time.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int N_OUT      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_dec,
  output logic             out_err,
  output logic [15:0]      acc_count
);

  mode_e            mode;
  logic             accept;
  logic             out_hs;
  logic [N_OUT-1:0] core_dec;
  logic             core_err;

  logic             in_ready_reg,   in_ready_next;
  logic             out_valid_reg,  out_valid_next;
  logic [N_OUT-1:0] out_dec_reg,    out_dec_next;
  logic             out_err_reg,    out_err_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [N_OUT-1:0] skid_dec_reg,   skid_dec_next;
  logic             skid_err_reg,   skid_err_next;
  logic [N_OUT-1:0] acc_reg,        acc_next;
  logic [CNT_W-1:0] cnt_reg,        cnt_next;

  assign mode   = mode_e'(in_mode);
  assign accept = in_valid & in_ready_reg;
  assign out_hs = out_valid_reg & out_ready;

  decoder_core #(
    .SEL_W(SEL_W),
    .N_OUT(N_OUT)
  ) u_core (
    .sel (in_sel),
    .mode(mode),
    .acc (acc_reg),
    .dec (core_dec),
    .err (core_err)
  );

  // An accept cannot coincide with a full skid because in_ready mirrors it.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_dec_next    = out_dec_reg;
    out_err_next    = out_err_reg;
    skid_valid_next = skid_valid_reg;
    skid_dec_next   = skid_dec_reg;
    skid_err_next   = skid_err_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;

    if (out_hs) begin
      cnt_next = cnt_reg + 1'b1;
      if (skid_valid_reg) begin
        out_dec_next    = skid_dec_reg;
        out_err_next    = skid_err_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_dec_next = core_dec;
        out_err_next = core_err;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg) begin
        out_valid_next = 1'b1;
        out_dec_next   = core_dec;
        out_err_next   = core_err;
      end else begin
        skid_valid_next = 1'b1;
        skid_dec_next   = core_dec;
        skid_err_next   = core_err;
      end
    end

    if (accept) begin
      if (mode == MODE_CLR) begin
        acc_next = '0;
      end else if (mode == MODE_ACC && !core_err) begin
        acc_next = core_dec;
      end
    end

    in_ready_next = ~skid_valid_next;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_dec_reg    <= '0;
      out_err_reg    <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_dec_reg   <= '0;
      skid_err_reg   <= 1'b0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
    end else begin
      in_ready_reg   <= in_ready_next;
      out_valid_reg  <= out_valid_next;
      out_dec_reg    <= out_dec_next;
      out_err_reg    <= out_err_next;
      skid_valid_reg <= skid_valid_next;
      skid_dec_reg   <= skid_dec_next;
      skid_err_reg   <= skid_err_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_err   = out_err_reg;
  assign out_dec   = ACTIVE_LOW ? ~out_dec_reg : out_dec_reg;
  assign acc_count = cnt_reg;

endmodule

// File: tb/tb_decoder_stream.sv
// Directed bench for decoder_stream: default, N_OUT=6 and ACTIVE_LOW=1 instances share stimulus.
module tb_decoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_sel;
  logic [1:0] in_mode;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_err;
  logic [7:0] a_out_dec;
  logic [15:0] a_cnt;
  logic       n_in_ready, n_out_valid, n_out_err;
  logic [5:0] n_out_dec;
  logic [15:0] n_cnt;
  logic       l_in_ready, l_out_valid, l_out_err;
  logic [7:0] l_out_dec;
  logic [15:0] l_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_stream dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sel(in_sel), .in_mode(in_mode), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_dec(a_out_dec), .out_err(a_out_err), .acc_count(a_cnt)
  );

  decoder_stream #(.SEL_W(3), .N_OUT(6)) dut_n6 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_sel(in_sel), .in_mode(in_mode), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_dec(n_out_dec), .out_err(n_out_err), .acc_count(n_cnt)
  );

  decoder_stream #(.ACTIVE_LOW(1'b1)) dut_al (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_sel(in_sel), .in_mode(in_mode), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_dec(l_out_dec), .out_err(l_out_err), .acc_count(l_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [2:0] s);
    in_mode  = m;
    in_sel   = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    $display("txn mode=%0d sel=%0d -> dec=%02h err=%0d n6=%02h/%0d al=%02h cnt=%0d",
             m, s, a_out_dec, a_out_err, n_out_dec, n_out_err, l_out_dec, a_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = 2'b00; out_ready = 1'b1;
    step(); step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0d exp=0", a_in_ready); end
    total++; if (a_out_dec !== 8'h00 || a_out_err !== 1'b0) begin bad++; $display("FAIL rst_dec got=%02h/%0d exp=00/0", a_out_dec, a_out_err); end
    total++; if (l_out_dec !== 8'hFF) begin bad++; $display("FAIL rst_al_dec got=%02h exp=ff", l_out_dec); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", a_cnt); end
    rst = 1'b0;
    step();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0d exp=1", a_in_ready); end
  endtask

  task automatic test_onehot();
    send(2'b00, 3'd5);
    total++; if (a_out_valid !== 1'b1 || a_out_dec !== 8'h20 || a_out_err !== 1'b0) begin bad++; $display("FAIL onehot5 got=%0d/%02h/%0d exp=1/20/0", a_out_valid, a_out_dec, a_out_err); end
    step();
    total++; if (a_cnt !== 16'd1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL onehot_cnt got=%0d/%0d exp=1/0", a_cnt, a_out_valid); end
  endtask

  task automatic test_modes();
    send(2'b01, 3'd3);
    total++; if (a_out_dec !== 8'h0F) begin bad++; $display("FAIL therm3 got=%02h exp=0f", a_out_dec); end
    send(2'b10, 3'd1);
    total++; if (a_out_dec !== 8'h02 || a_in_ready !== 1'b1) begin bad++; $display("FAIL acc1 got=%02h/%0d exp=02/1", a_out_dec, a_in_ready); end
    send(2'b10, 3'd6);
    total++; if (a_out_dec !== 8'h42) begin bad++; $display("FAIL acc6 got=%02h exp=42", a_out_dec); end
    total++; if (n_out_dec !== 6'h00 || n_out_err !== 1'b1) begin bad++; $display("FAIL n6_acc6 got=%02h/%0d exp=00/1", n_out_dec, n_out_err); end
    send(2'b11, 3'd7);
    total++; if (a_out_dec !== 8'h00 || a_out_err !== 1'b0) begin bad++; $display("FAIL clr got=%02h/%0d exp=00/0", a_out_dec, a_out_err); end
    send(2'b10, 3'd0);
    total++; if (a_out_dec !== 8'h01) begin bad++; $display("FAIL acc_after_clr got=%02h exp=01", a_out_dec); end
    step();
    total++; if (a_cnt !== 16'd6) begin bad++; $display("FAIL modes_cnt got=%0d exp=6", a_cnt); end
  endtask

  task automatic test_range();
    send(2'b00, 3'd7);
    total++; if (n_out_dec !== 6'h00 || n_out_err !== 1'b1) begin bad++; $display("FAIL n6_sel7 got=%02h/%0d exp=00/1", n_out_dec, n_out_err); end
    total++; if (a_out_dec !== 8'h80 || a_out_err !== 1'b0) begin bad++; $display("FAIL sel7 got=%02h/%0d exp=80/0", a_out_dec, a_out_err); end
    send(2'b10, 3'd2);
    total++; if (n_out_dec !== 6'h05 || n_out_err !== 1'b0) begin bad++; $display("FAIL n6_acc_kept got=%02h/%0d exp=05/0", n_out_dec, n_out_err); end
    send(2'b10, 3'd5);
    total++; if (n_out_dec !== 6'h25 || n_out_err !== 1'b0) begin bad++; $display("FAIL n6_top_sel got=%02h/%0d exp=25/0", n_out_dec, n_out_err); end
    step();
  endtask

  task automatic test_back_to_back();
    send(2'b11, 3'd0);
    step();
    out_ready = 1'b0;
    in_mode = 2'b10; in_valid = 1'b1; in_sel = 3'd1;
    step();
    total++; if (a_out_valid !== 1'b1 || a_out_dec !== 8'h02 || a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_first got=%0d/%02h/%0d exp=1/02/1", a_out_valid, a_out_dec, a_in_ready); end
    in_sel = 3'd2;
    step();
    total++; if (a_in_ready !== 1'b0 || a_out_dec !== 8'h02) begin bad++; $display("FAIL bp_skid got=%0d/%02h exp=0/02", a_in_ready, a_out_dec); end
    in_sel = 3'd3;
    step();
    total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_dec !== 8'h02) begin bad++; $display("FAIL bp_hold got=%0d/%0d/%02h exp=0/1/02", a_in_ready, a_out_valid, a_out_dec); end
    out_ready = 1'b1;
    step();
    total++; if (a_out_dec !== 8'h06 || a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain1 got=%02h/%0d exp=06/1", a_out_dec, a_in_ready); end
    step();
    total++; if (a_out_dec !== 8'h0E || a_out_valid !== 1'b1) begin bad++; $display("FAIL bp_drain2 got=%02h/%0d exp=0e/1", a_out_dec, a_out_valid); end
    in_valid = 1'b0;
    step();
    total++; if (a_out_valid !== 1'b0 || a_cnt !== 16'd13) begin bad++; $display("FAIL bp_done got=%0d/%0d exp=0/13", a_out_valid, a_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_mode = 2'b00; in_valid = 1'b1; in_sel = 3'd0;
    step();
    in_sel = 3'd1;
    step();
    in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0d/%0d exp=1/0", a_out_valid, a_in_ready); end
    rst = 1'b1;
    step();
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst got=%0d/%0d/%0d exp=0/0/0", a_out_valid, a_in_ready, a_cnt); end
    rst = 1'b0; out_ready = 1'b1;
    step();
    total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL mid_release got=%0d/%0d exp=1/0", a_in_ready, a_out_valid); end
    send(2'b10, 3'd3);
    total++; if (a_out_dec !== 8'h08) begin bad++; $display("FAIL mid_acc_cleared got=%02h exp=08", a_out_dec); end
    step();
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL mid_cnt got=%0d exp=1", a_cnt); end
  endtask

  task automatic test_active_low();
    send(2'b00, 3'd2);
    total++; if (l_out_dec !== 8'hFB || l_out_err !== 1'b0) begin bad++; $display("FAIL al_sel2 got=%02h/%0d exp=fb/0", l_out_dec, l_out_err); end
    total++; if (a_out_dec !== 8'h04) begin bad++; $display("FAIL hi_sel2 got=%02h exp=04", a_out_dec); end
    step();
  endtask

  task automatic test_wrap();
    int guard = 0;
    in_mode = 2'b00; in_sel = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    while (a_cnt !== 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    in_valid = 1'b0;
    total++; if (a_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_reach got=%04h exp=ffff", a_cnt); end
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL wrap_pending got=%0d exp=1", a_out_valid); end
    step();
    $display("txn wrap handshake -> cnt=%04h", a_cnt);
    total++; if (a_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%04h exp=0000", a_cnt); end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_modes();
    test_range();
    test_back_to_back();
    test_reset_mid();
    test_active_low();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
